// File: rtl/gfx_mem_pkg.sv
// rtl/gfx_mem_pkg.sv - shared client ids and widths for the gfx memory arbiter
package gfx_mem_pkg;

  localparam int NUM_CLIENTS    = 4;
  localparam int CLIENT_ID_BITS = 2;

  localparam int CLIENT_SPCON = 0;
  localparam int CLIENT_BG0   = 1;
  localparam int CLIENT_BG1   = 2;
  localparam int CLIENT_OV    = 3;

  typedef logic [CLIENT_ID_BITS-1:0] client_id_t;

endpackage

// File: rtl/gfx_mem_arbiter_rr.sv
// rtl/gfx_mem_arbiter_rr.sv - combinational 4-way round-robin pick
module rr_arbiter4
  import gfx_mem_pkg::*;
(
  input  logic [NUM_CLIENTS-1:0] req,
  input  client_id_t             ptr,
  output logic [NUM_CLIENTS-1:0] grant,
  output client_id_t             grant_idx,
  output logic                   grant_valid
);

  client_id_t cand;

  // Scan from ptr upward with 2-bit wraparound; first requester wins.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand        = '0;
    for (int k = 0; k < NUM_CLIENTS; k++) begin
      cand = ptr + client_id_t'(k);
      if (!grant_valid && req[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gfx_mem_arbiter.sv
// rtl/gfx_mem_arbiter.sv - round-robin read responder for four gfx fetch ports
module gfx_mem_arbiter
  import gfx_mem_pkg::*;
#(
  parameter int MEM_LATENCY = 2,
  parameter int ADDR_BITS   = 16,
  parameter int DATA_BITS   = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [ADDR_BITS-1:0] spcon_memory_address,
  input  logic                 spcon_rvalid,
  output logic [DATA_BITS-1:0] spcon_memory_data,
  output logic                 spcon_rready,
  input  logic [ADDR_BITS-1:0] bg0_memory_address,
  input  logic                 bg0_rvalid,
  output logic [DATA_BITS-1:0] bg0_memory_data,
  output logic                 bg0_rready,
  input  logic [ADDR_BITS-1:0] bg1_memory_address,
  input  logic                 bg1_rvalid,
  output logic [DATA_BITS-1:0] bg1_memory_data,
  output logic                 bg1_rready,
  input  logic [ADDR_BITS-1:0] ov_memory_address,
  input  logic                 ov_rvalid,
  output logic [DATA_BITS-1:0] ov_memory_data,
  output logic                 ov_rready,
  output logic [ADDR_BITS-1:0] mem_address,
  output logic                 mem_rd,
  input  logic [DATA_BITS-1:0] mem_data
);

  logic [NUM_CLIENTS-1:0] rvalid;
  logic [NUM_CLIENTS-1:0] rready;
  logic [NUM_CLIENTS-1:0] pending;
  logic [NUM_CLIENTS-1:0] eligible;
  logic [NUM_CLIENTS-1:0] grant;
  logic [NUM_CLIENTS-1:0] ret;
  logic [ADDR_BITS-1:0]   req_addr [NUM_CLIENTS];
  logic [DATA_BITS-1:0]   rd_data  [NUM_CLIENTS];
  client_id_t             rr_ptr;
  client_id_t             grant_idx;
  client_id_t             mem_id;
  logic                   grant_valid;
  logic [MEM_LATENCY-1:0] pipe_valid;
  client_id_t             pipe_id [MEM_LATENCY];

  assign rvalid = {ov_rvalid, bg1_rvalid, bg0_rvalid, spcon_rvalid};

  assign req_addr[CLIENT_SPCON] = spcon_memory_address;
  assign req_addr[CLIENT_BG0]   = bg0_memory_address;
  assign req_addr[CLIENT_BG1]   = bg1_memory_address;
  assign req_addr[CLIENT_OV]    = ov_memory_address;

  // rvalid seen during a client's own rready cycle still belongs to the old request.
  assign eligible = rvalid & ~pending & ~rready;

  rr_arbiter4 u_arb (
    .req         (eligible),
    .ptr         (rr_ptr),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  always_comb begin
    ret = '0;
    if (pipe_valid[MEM_LATENCY-1]) ret[pipe_id[MEM_LATENCY-1]] = 1'b1;
  end

  // mem_rd/mem_id form the grant stage; the pipe behind it lines the id up with mem_data.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rr_ptr      <= '0;
      pending     <= '0;
      rready      <= '0;
      mem_rd      <= 1'b0;
      mem_address <= '0;
      mem_id      <= '0;
      pipe_valid  <= '0;
      for (int i = 0; i < MEM_LATENCY; i++) pipe_id[i] <= '0;
      for (int i = 0; i < NUM_CLIENTS; i++) rd_data[i] <= '0;
    end else begin
      if (grant_valid) begin
        rr_ptr      <= grant_idx + 2'd1;
        mem_address <= req_addr[grant_idx];
        mem_id      <= grant_idx;
      end
      mem_rd        <= grant_valid;
      pipe_valid[0] <= mem_rd;
      pipe_id[0]    <= mem_id;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_id[i]    <= pipe_id[i-1];
      end
      if (pipe_valid[MEM_LATENCY-1]) rd_data[pipe_id[MEM_LATENCY-1]] <= mem_data;
      rready  <= ret;
      pending <= (pending | grant) & ~ret;
    end
  end

  assign spcon_memory_data = rd_data[CLIENT_SPCON];
  assign bg0_memory_data   = rd_data[CLIENT_BG0];
  assign bg1_memory_data   = rd_data[CLIENT_BG1];
  assign ov_memory_data    = rd_data[CLIENT_OV];

  assign spcon_rready = rready[CLIENT_SPCON];
  assign bg0_rready   = rready[CLIENT_BG0];
  assign bg1_rready   = rready[CLIENT_BG1];
  assign ov_rready    = rready[CLIENT_OV];

endmodule

// File: tb/tb_gfx_mem_arbiter.sv
// tb/tb_gfx_mem_arbiter.sv - directed bench; instance 0 at latency 2, instances 1/2 at latency 1/4
module tb_gfx_mem_arbiter;

  localparam logic [15:0] KEY = 16'hACDB;

  logic                  CLK = 1'b0;
  logic                  RST = 1'b1;
  logic [3:0][15:0]      addr;
  logic [2:0][3:0]       rv;
  logic [2:0][3:0]       rdy;
  logic [2:0][3:0][15:0] dout;
  logic [2:0][15:0]      maddr;
  logic [2:0][15:0]      mdata;
  logic [2:0]            mrd;

  int checks = 0;
  int errors = 0;

  logic [15:0] s2_exp [4];
  logic [3:0]  outst, elig_prev, rdy_prev, renew;
  logic [3:0]  served [4];
  logic [15:0] gaddr [4];
  int          seq [4];
  int          nrdy, nrd;
  logic [1:0]  gid;

  always #5 CLK = ~CLK;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
    logic [15:0] mq [LAT];

    gfx_mem_arbiter #(.MEM_LATENCY(LAT), .ADDR_BITS(16), .DATA_BITS(16)) dut (
      .CLK                  (CLK),
      .RST                  (RST),
      .spcon_memory_address (addr[0]),
      .spcon_rvalid         (rv[g][0]),
      .spcon_memory_data    (dout[g][0]),
      .spcon_rready         (rdy[g][0]),
      .bg0_memory_address   (addr[1]),
      .bg0_rvalid           (rv[g][1]),
      .bg0_memory_data      (dout[g][1]),
      .bg0_rready           (rdy[g][1]),
      .bg1_memory_address   (addr[2]),
      .bg1_rvalid           (rv[g][2]),
      .bg1_memory_data      (dout[g][2]),
      .bg1_rready           (rdy[g][2]),
      .ov_memory_address    (addr[3]),
      .ov_rvalid            (rv[g][3]),
      .ov_memory_data       (dout[g][3]),
      .ov_rready            (rdy[g][3]),
      .mem_address          (maddr[g]),
      .mem_rd               (mrd[g]),
      .mem_data             (mdata[g])
    );

    // Memory returns address ^ KEY, LAT cycles after the address is presented.
    always @(posedge CLK) begin
      mq[0] <= maddr[g];
      for (int i = 1; i < LAT; i++) mq[i] <= mq[i-1];
    end
    assign mdata[g] = mq[LAT-1] ^ KEY;
  end

  function automatic int lat_of(input int g);
    return (g == 0) ? 2 : ((g == 1) ? 1 : 4);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    rv  = '0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    chk("rst_rready", 32'(rdy[0]), 0);
    chk("rst_mem_rd", 32'(mrd[0]), 0);
    chk("rst_mem_addr", 32'(maddr[0]), 0);
    for (int i = 0; i < 4; i++) chk("rst_data", 32'(dout[0][i]), 0);
  endtask

  initial begin
    addr = '0;
    rv   = '0;
    s2_exp[0] = 16'hBCDB;
    s2_exp[1] = 16'h8CDB;
    s2_exp[2] = 16'h9CDB;
    s2_exp[3] = 16'hECDB;

    // single bg0 request on all three latencies
    do_reset();
    addr[1] = 16'h1234;
    for (int c = 0; c < 10; c++) begin
      @(posedge CLK); #1;
      if (c == 0) for (int g = 0; g < 3; g++) rv[g][1] = 1'b1;
      @(negedge CLK);
      chk("s1_mem_rd", 32'(mrd[0]), 32'(c == 1));
      if (c == 1) chk("s1_mem_addr", 32'(maddr[0]), 32'h1234);
      for (int g = 0; g < 3; g++) begin
        chk($sformatf("s1_rready_lat%0d", lat_of(g)), 32'(rdy[g][1]), 32'(c == lat_of(g) + 2));
        if (rdy[g][1]) begin
          chk($sformatf("s1_data_lat%0d", lat_of(g)), 32'(dout[g][1]), 32'hBEEF);
          rv[g][1] = 1'b0;
        end
      end
    end

    // all four at once from pointer 0
    do_reset();
    addr[0] = 16'h1000; addr[1] = 16'h2000; addr[2] = 16'h3000; addr[3] = 16'h4000;
    for (int c = 0; c < 10; c++) begin
      @(posedge CLK); #1;
      if (c == 0) rv[0] = 4'hF;
      @(negedge CLK);
      chk("s2_mem_rd", 32'(mrd[0]), 32'(c >= 1 && c <= 4));
      if (c >= 1 && c <= 4) chk("s2_mem_addr", 32'(maddr[0]), 32'(addr[c-1]));
      chk("s2_rready", 32'(rdy[0]), (c >= 4 && c <= 7) ? 32'(1 << (c - 4)) : 32'h0);
      for (int i = 0; i < 4; i++)
        if (rdy[0][i]) begin
          chk("s2_data", 32'(dout[0][i]), 32'(s2_exp[i]));
          rv[0][i] = 1'b0;
        end
    end

    // persistent contention, immediate re-request
    do_reset();
    outst = '0; elig_prev = '0; rdy_prev = '0; renew = '0; nrdy = 0;
    for (int i = 0; i < 4; i++) begin served[i] = '0; seq[i] = 0; gaddr[i] = '0; end
    for (int c = 0; c < 20; c++) begin
      @(posedge CLK); #1;
      for (int i = 0; i < 4; i++)
        if (c == 0 || renew[i]) begin
          seq[i]++;
          addr[i] = 16'(i << 12) | 16'(seq[i]);
        end
      if (c == 0) rv[0] = 4'hF;
      renew = '0;
      @(negedge CLK);
      if (mrd[0]) begin
        gid = maddr[0][13:12];
        chk("s3_one_outstanding", 32'(outst[gid]), 0);
        chk("s3_gnt_addr", 32'(maddr[0]), 32'(addr[gid]));
        for (int j = 0; j < 4; j++)
          if (j != int'(gid) && elig_prev[j]) begin
            chk("s3_fair", 32'(served[j][gid]), 0);
            served[j][gid] = 1'b1;
          end
        served[gid] = '0;
        outst[gid]  = 1'b1;
        gaddr[gid]  = maddr[0];
      end
      for (int i = 0; i < 4; i++)
        if (rdy[0][i]) begin
          chk("s3_rready_width", 32'(rdy_prev[i]), 0);
          chk("s3_data", 32'(dout[0][i]), 32'(gaddr[i] ^ KEY));
          outst[i] = 1'b0;
          renew[i] = 1'b1;
          nrdy++;
        end
      rdy_prev  = rdy[0];
      elig_prev = rv[0] & ~outst & ~rdy[0];
    end
    chk("s3_rready_count", 32'(nrdy), 13);

    // rvalid held through rready, new address next cycle
    do_reset();
    nrd = 0;
    for (int c = 0; c < 13; c++) begin
      @(posedge CLK); #1;
      if (c == 0) begin addr[3] = 16'h0AAA; rv[0][3] = 1'b1; end
      if (c == 5) addr[3] = 16'h0BBB;
      if (c == 10) rv[0][3] = 1'b0;
      @(negedge CLK);
      if (mrd[0]) nrd++;
      if (c == 1) chk("s4_first_addr", 32'(maddr[0]), 32'h0AAA);
      if (c == 6) begin
        chk("s4_regrant_rd", 32'(mrd[0]), 1);
        chk("s4_regrant_addr", 32'(maddr[0]), 32'h0BBB);
      end
      chk("s4_rready", 32'(rdy[0]), (c == 4 || c == 9) ? 32'h8 : 32'h0);
      if (c == 4) chk("s4_data0", 32'(dout[0][3]), 32'hA671);
      if (c == 9) chk("s4_data1", 32'(dout[0][3]), 32'hA760);
    end
    chk("s4_rd_count", 32'(nrd), 2);

    // reset one cycle after mem_rd while memory still returns data
    for (int c = 0; c < 9; c++) begin
      @(posedge CLK); #1;
      if (c == 0) begin addr[0] = 16'h5555; rv[0][0] = 1'b1; end
      if (c == 2) begin RST = 1'b1; rv[0] = '0; end
      if (c == 3) RST = 1'b0;
      @(negedge CLK);
      if (c == 1) chk("s5_mem_rd", 32'(mrd[0]), 1);
      chk("s5_no_rready", 32'(rdy[0]), 0);
      if (c == 3) begin
        chk("s5_mem_rd_clr", 32'(mrd[0]), 0);
        chk("s5_mem_addr_clr", 32'(maddr[0]), 0);
        for (int i = 0; i < 4; i++) chk("s5_data_clr", 32'(dout[0][i]), 0);
      end
    end
    addr[2] = 16'h2468;
    for (int c = 0; c < 8; c++) begin
      @(posedge CLK); #1;
      if (c == 0) rv[0][2] = 1'b1;
      @(negedge CLK);
      chk("s5_fresh_rready", 32'(rdy[0]), (c == 4) ? 32'h4 : 32'h0);
      if (rdy[0][2]) begin
        chk("s5_fresh_data", 32'(dout[0][2]), 32'h88B3);
        rv[0][2] = 1'b0;
      end
    end

    // pointer left at 3 by the bg1 grant: overlay beats sprite
    addr[0] = 16'h0111; addr[3] = 16'h0333;
    for (int c = 0; c < 8; c++) begin
      @(posedge CLK); #1;
      if (c == 0) rv[0] = 4'b1001;
      @(negedge CLK);
      if (c == 1) chk("s6_first_addr", 32'(maddr[0]), 32'h0333);
      if (c == 2) chk("s6_second_addr", 32'(maddr[0]), 32'h0111);
      chk("s6_rready", 32'(rdy[0]), (c == 4) ? 32'h8 : ((c == 5) ? 32'h1 : 32'h0));
      if (rdy[0][3]) begin chk("s6_ov_data", 32'(dout[0][3]), 32'hAFE8); rv[0][3] = 1'b0; end
      if (rdy[0][0]) begin chk("s6_sp_data", 32'(dout[0][0]), 32'hADCA); rv[0][0] = 1'b0; end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
